// File: rtl/alu_defs.sv
// Shared encodings for the alu_md_seq execute unit: base ALU codes,
// M-extension funct3 codes and the sequencer state encoding.
package alu_defs;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SLT  = 4'b1101,
        OP_SLTU = 4'b1111
    } base_op_e;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// One step is applied on start and one per cycle after, N steps in total.
module md_iter_core
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_result
);
    localparam int CW = $clog2(N);

    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_d;
    logic [N-1:0]   r_a;
    logic [2:0]     r_op;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_div0;
    logic           r_active;
    logic [CW-1:0]  r_left;

    logic           w_sa;
    logic           w_sb;
    logic           w_neg_a;
    logic           w_neg_b;
    logic           w_is_div;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N-1:0]   w_init_lo;
    logic [N-1:0]   w_init_d;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;

    // mul: {hi,lo} is accumulator:multiplier; div: hi is partial remainder, lo shifts dividend out / quotient in
    function automatic logic [2*N-1:0] step(input logic is_div, input logic [N-1:0] hi,
                                            input logic [N-1:0] lo, input logic [N-1:0] d);
        logic [N:0] sum;
        logic [N:0] rr;
        logic [N:0] diff;
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        rr   = {hi, lo[N-1]};
        diff = rr - {1'b0, d};
        if (!is_div)
            return {sum, lo[N-1:1]};
        else if (!diff[N])
            return {diff[N-1:0], lo[N-2:0], 1'b1};
        else
            return {rr[N-1:0], lo[N-2:0], 1'b0};
    endfunction

    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        case (i_op)
            F3_MULH, F3_DIV, F3_REM: begin
                w_sa = 1'b1;
                w_sb = 1'b1;
            end
            F3_MULHSU: w_sa = 1'b1;
            default: ;
        endcase
    end

    assign w_is_div  = i_op[2];
    assign w_neg_a   = w_sa & i_a[N-1];
    assign w_neg_b   = w_sb & i_b[N-1];
    assign w_a_mag   = w_neg_a ? -i_a : i_a;
    assign w_b_mag   = w_neg_b ? -i_b : i_b;
    assign w_init_lo = w_is_div ? w_a_mag : w_b_mag;
    assign w_init_d  = w_is_div ? w_b_mag : w_a_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
            r_a      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_active <= 1'b0;
            r_left   <= '0;
        end else if (i_start) begin
            {r_hi, r_lo} <= step(w_is_div, '0, w_init_lo, w_init_d);
            r_d      <= w_init_d;
            r_a      <= i_a;
            r_op     <= i_op;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div0   <= (i_b == '0);
            r_active <= 1'b1;
            r_left   <= CW'(N - 1);
        end else if (r_active && r_left != '0) begin
            {r_hi, r_lo} <= step(r_op[2], r_hi, r_lo, r_d);
            r_left       <= r_left - 1'b1;
        end
    end

    assign o_done = r_active && (r_left == '0);

    // MIN/-1 needs no special case: |MIN|/1 leaves 2^(N-1) which already reads as MIN
    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg_q ? -r_lo : r_lo;
    assign w_rem  = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        o_result = '0;
        case (r_op)
            F3_MUL:                        o_result = w_prod[N-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[2*N-1:N];
            F3_DIV, F3_DIVU:               o_result = r_div0 ? '1 : w_quo;
            F3_REM, F3_REMU:               o_result = r_div0 ? r_a : w_rem;
            default:                       o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_md_seq.sv
// EX-stage execute unit: single-cycle base ALU plus iterative RV32M ops,
// with a valid/ready handshake on both sides and a registered result.
module alu_md_seq
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         Zerof,
    output logic         Sf,
    output logic         Vf,
    output logic         C,
    output logic         busy,
    output state_e       o_dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; out/flags/out_valid stay frozen while out_valid && !out_ready.
    localparam int SHW = $clog2(N);
    localparam int CW  = $clog2(N);

    state_e         r_state;
    state_e         w_next;
    logic [CW-1:0]  r_count;
    logic [N-1:0]   r_out;
    logic           r_zf;
    logic           r_sf;
    logic           r_vf;
    logic           r_c;

    logic           w_accept;
    logic           w_md_start;
    logic           w_md_done;
    logic           w_md_finish;
    logic [N-1:0]   w_md_result;
    logic [SHW-1:0] w_shamt;
    logic [N:0]     w_add;
    logic [N:0]     w_sub;
    logic [N-1:0]   w_base_res;
    logic           w_base_v;
    logic           w_base_c;

    assign in_ready    = !rst && !flush && (r_state == ST_IDLE || (r_state == ST_DONE && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_md_start  = w_accept && op[4];
    assign w_md_finish = !flush && (r_state == ST_BUSY) && (r_count == '0) && w_md_done;

    md_iter_core #(.N(N)) u_md (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_op     (op[2:0]),
        .i_a      (A),
        .i_b      (B),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign w_shamt = B[SHW-1:0];
    assign w_add   = {1'b0, A} + {1'b0, B};
    assign w_sub   = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};

    always_comb begin
        w_base_res = '0;
        w_base_v   = 1'b0;
        w_base_c   = 1'b0;
        case (op[3:0])
            OP_ADD: begin
                w_base_res = w_add[N-1:0];
                w_base_c   = w_add[N];
                w_base_v   = (A[N-1] == B[N-1]) && (w_add[N-1] != A[N-1]);
            end
            OP_SUB: begin
                w_base_res = w_sub[N-1:0];
                w_base_c   = w_sub[N];
                w_base_v   = (A[N-1] != B[N-1]) && (w_sub[N-1] != A[N-1]);
            end
            OP_SLL:  w_base_res = A << w_shamt;
            OP_SRL:  w_base_res = A >> w_shamt;
            OP_SRA:  w_base_res = $unsigned($signed(A) >>> w_shamt);
            OP_SLT:  w_base_res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_base_res = {{(N-1){1'b0}}, (A < B)};
            OP_XOR:  w_base_res = A ^ B;
            OP_AND:  w_base_res = A & B;
            OP_OR:   w_base_res = A | B;
            default: w_base_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = op[4] ? ST_BUSY : ST_DONE;
            ST_BUSY: if (r_count == '0 && w_md_done) w_next = ST_DONE;
            ST_DONE: begin
                if (w_accept)       w_next = op[4] ? ST_BUSY : ST_DONE;
                else if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_count <= '0;
        else if (w_md_start)
            r_count <= CW'(N - 1);
        else if (r_state == ST_BUSY && r_count != '0)
            r_count <= r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_zf  <= 1'b1;
            r_sf  <= 1'b0;
            r_vf  <= 1'b0;
            r_c   <= 1'b0;
        end else if (w_accept && !op[4]) begin
            r_out <= w_base_res;
            r_zf  <= (w_base_res == '0);
            r_sf  <= w_base_res[N-1];
            r_vf  <= w_base_v;
            r_c   <= w_base_c;
        end else if (w_md_finish) begin
            r_out <= w_md_result;
            r_zf  <= (w_md_result == '0);
            r_sf  <= w_md_result[N-1];
            r_vf  <= 1'b0;
            r_c   <= 1'b0;
        end
    end

    assign out         = r_out;
    assign Zerof       = r_zf;
    assign Sf          = r_sf;
    assign Vf          = r_vf;
    assign C           = r_c;
    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state == ST_BUSY);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_md_seq.sv
// Directed scoreboard bench for alu_md_seq: the driver pushes hand-computed
// results, a negedge monitor pops them on every output transfer.
module tb_alu_md_seq;
  import alu_defs::*;

  localparam int N = 32;
  localparam int W = N + 4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         Zerof;
  logic         Sf;
  logic         Vf;
  logic         C;
  logic         busy;
  state_e       dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  alu_md_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .Zerof       (Zerof),
    .Sf          (Sf),
    .Vf          (Vf),
    .C           (C),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [4:0] bop(input base_op_e o);
    return {1'b0, 4'(o)};
  endfunction

  function automatic logic [4:0] mop(input md_op_e o);
    return {2'b10, 3'(o)};
  endfunction

  // expected word is {out, Zerof, Sf, Vf, C}; Z and S derive from the expected result
  function automatic logic [W-1:0] mk_exp(input logic [N-1:0] r, input logic v, input logic c);
    return {r, (r == '0), r[N-1], v, c};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(out), 64'hDEAD_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("result_out_flags", 64'({out, Zerof, Sf, Vf, C}), 64'(e));
      end
    end
  end

  // driver: issue one op, push its expectation at the accept edge, check latency
  task automatic issue(input string name, input logic [4:0] o, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] eo, input logic ev,
                       input logic ec, input int lat);
    int k;
    int cyc;
    int nbusy;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; A = a; B = b;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    check({name, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(mk_exp(eo, ev, ec));
    #1;
    in_valid = 1'b0;
    op = 5'($urandom_range(0, 31));
    A = $urandom;
    B = $urandom;
    cyc = 0;
    nbusy = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (out_valid) break;
    end
    check({name, "_latency"}, 64'(cyc), 64'(lat));
    check({name, "_busy_cycles"}, 64'(nbusy), 64'((lat > 1) ? N : 0));
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},       64'(out),       64'd0);
    check({tag, "_zerof"},     64'(Zerof),     64'd1);
    check({tag, "_sf_vf_c"},   64'({Sf, Vf, C}), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_state"},     64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    int k;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; A = '0; B = '0;
    @(negedge clk);
    check("in_ready_during_reset", 64'(in_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // base ops
    issue("add_ovf",  bop(OP_ADD),  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b1, 1'b0, 1);
    issue("sub_zero", bop(OP_SUB),  32'd5,         32'd5,          32'h0,         1'b0, 1'b1, 1);
    issue("add_carry",bop(OP_ADD),  32'hFFFF_FFFF, 32'h1,          32'h0,         1'b0, 1'b1, 1);
    issue("sub_borrow",bop(OP_SUB), 32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    issue("sub_ovf",  bop(OP_SUB),  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b1, 1'b1, 1);
    issue("srl",      bop(OP_SRL),  32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0, 1'b0, 1);
    issue("sra",      bop(OP_SRA),  32'h8000_0000, 32'd4,          32'hF800_0000, 1'b0, 1'b0, 1);
    issue("sll_wrap", bop(OP_SLL),  32'h1,         32'd36,         32'h10,        1'b0, 1'b0, 1);
    issue("slt",      bop(OP_SLT),  32'hFFFF_FFFF, 32'h1,          32'h1,         1'b0, 1'b0, 1);
    issue("sltu",     bop(OP_SLTU), 32'hFFFF_FFFF, 32'h1,          32'h0,         1'b0, 1'b0, 1);
    issue("and",      bop(OP_AND),  32'hF0F0_1234, 32'h0FF0_FF00,  32'h00F0_1200, 1'b0, 1'b0, 1);
    issue("or",       bop(OP_OR),   32'hF000_0001, 32'h0000_0F00,  32'hF000_0F01, 1'b0, 1'b0, 1);
    issue("undef",    5'b0_0101,    32'h1234_5678, 32'h1,          32'h0,         1'b0, 1'b0, 1);

    // M ops
    issue("mul",      mop(F3_MUL),    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, N + 1);
    issue("mulhu",    mop(F3_MULHU),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, N + 1);
    issue("mulh",     mop(F3_MULH),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, N + 1);
    issue("mulhsu",   mop(F3_MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, N + 1);
    issue("div_neg",  mop(F3_DIV),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, N + 1);
    issue("rem_neg",  mop(F3_REM),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, N + 1);
    issue("div_ovf",  mop(F3_DIV),    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, N + 1);
    issue("rem_ovf",  mop(F3_REM),    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, N + 1);
    issue("divu_0",   mop(F3_DIVU),   32'd13,        32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, N + 1);
    issue("remu_0",   mop(F3_REMU),   32'd13,        32'd0,         32'd13,        1'b0, 1'b0, N + 1);
    issue("div_0",    mop(F3_DIV),    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, N + 1);
    issue("rem_0",    mop(F3_REM),    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, 1'b0, N + 1);
    issue("divu",     mop(F3_DIVU),   32'd100,       32'd7,         32'd14,        1'b0, 1'b0, N + 1);
    issue("remu",     mop(F3_REMU),   32'd100,       32'd7,         32'd2,         1'b0, 1'b0, N + 1);

    // backpressure then back-to-back accept
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("xor_hold", bop(OP_XOR), 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_out", 64'(out), 64'h5A5A_A5A5);
      check("hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op = bop(OP_SLL); A = 32'h1; B = 32'd31;
    @(negedge clk);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(mk_exp(32'h8000_0000, 1'b0, 1'b0));
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", 64'({out_valid, out}), 64'({1'b1, 32'h8000_0000}));

    // flush during a divide, with a competing op presented
    @(posedge clk); #1;
    in_valid = 1'b1; op = mop(F3_DIV); A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = bop(OP_ADD); A = 32'd1; B = 32'd1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_state", 64'(dbg_state), 64'(ST_IDLE));
    check("flush_valid_busy", 64'({out_valid, busy}), 64'd0);
    watch_quiet("flush_no_result", 40);

    // reset in the middle of a multiply
    @(posedge clk); #1;
    in_valid = 1'b1; op = mop(F3_MUL); A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midop_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_rst");
    watch_quiet("rst_no_result", 40);

    issue("add_after", bop(OP_ADD), 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
